// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller for the 5-stage core: per-operand forward selects
// registered into EX, load-use stall and taken-branch flush sequencing, and event counters.
package hazard_fwd_ctrl_pkg;
  typedef enum logic [1:0] {
    from_Reg    = 2'b00,
    from_mem_wb = 2'b01,
    from_ex_mem = 2'b10
  } fwd_e;

  typedef enum logic [1:0] {RUN, STALL, FLUSH} hz_state_e;
endpackage

// One ALU operand: compares the ID source register against EX/MEM destinations
// and keeps the EX-visible forward select register.
module hazard_fwd_op
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic                  kill,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic                  uses,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  output fwd_e                  fwd,
  output logic                  luse_hit
);
  logic ex_hit, mem_hit;
  fwd_e fwd_d;

  assign ex_hit   = uses && ex_reg_write  && (ex_rd  != '0) && (ex_rd  == rs);
  assign mem_hit  = uses && mem_reg_write && (mem_rd != '0) && (mem_rd == rs);
  assign luse_hit = ex_hit && ex_mem_read;

  // A load in EX has no data yet, so it never forwards; MEM only wins when EX doesn't.
  always_comb begin
    fwd_d = from_Reg;
    if (ex_hit && !ex_mem_read) fwd_d = from_ex_mem;
    else if (mem_hit)           fwd_d = from_mem_wb;
  end

  always_ff @(posedge clk) begin
    if (rst)        fwd <= from_Reg;
    else if (!hold) fwd <= kill ? from_Reg : fwd_d;
  end
endmodule

module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic                  branch_taken,
  input  logic                  ext_hold,
  output fwd_e                  ForwardA,
  output fwd_e                  ForwardB,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  id_ex_bubble,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);
  localparam int NUM_OPS = 2;

  logic [NUM_OPS-1:0][REG_ADDR_W-1:0] id_rs;
  logic [NUM_OPS-1:0]                 id_uses;
  logic [NUM_OPS-1:0]                 luse_hit;
  fwd_e [NUM_OPS-1:0]                 fwd_q;
  logic                               luse, stall_go, kill;
  hz_state_e                          state_q, state_d;

  assign id_rs   = {id_rs2, id_rs1};
  assign id_uses = {id_uses_rs2, id_uses_rs1};

  generate
    for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
      hazard_fwd_op #(.REG_ADDR_W(REG_ADDR_W)) u_op (
        .clk          (clk),
        .rst          (rst),
        .hold         (ext_hold),
        .kill         (kill),
        .rs           (id_rs[g]),
        .uses         (id_uses[g]),
        .ex_rd        (ex_rd),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .mem_rd       (mem_rd),
        .mem_reg_write(mem_reg_write),
        .fwd          (fwd_q[g]),
        .luse_hit     (luse_hit[g])
      );
    end
  endgenerate

  assign ForwardA = fwd_q[0];
  assign ForwardB = fwd_q[1];

  assign luse     = |luse_hit;
  assign stall_go = luse && !branch_taken;
  // Bubble or flushed slot enters EX, so it must not inherit a forward select.
  assign kill     = branch_taken || luse;

  assign pc_stall     = stall_go;
  assign if_id_stall  = stall_go;
  assign id_ex_bubble = stall_go;
  assign if_id_flush  = branch_taken;
  assign id_ex_flush  = branch_taken;

  // Every state re-evaluates from the current hazards; STALL->STALL covers back-to-back loads.
  always_comb begin
    state_d = state_q;
    if (!ext_hold) begin
      unique case (state_q)
        RUN, STALL, FLUSH: state_d = branch_taken ? FLUSH : (luse ? STALL : RUN);
        default:           state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state_q <= state_d;
      if (!ext_hold) begin
        if (stall_go && stall_count != '1)     stall_count <= stall_count + 1'b1;
        if (branch_taken && flush_count != '1) flush_count <= flush_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: combinational controls checked before each edge,
// registered selects and counters checked from a scoreboard queue after the edge.
module tb_hazard_fwd_ctrl;
  import hazard_fwd_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_reg_write, ex_mem_read, mem_reg_write;
  logic       branch_taken, ext_hold;
  fwd_e       ForwardA, ForwardB;
  logic       pc_stall, if_id_stall, id_ex_bubble, if_id_flush, id_ex_flush;
  logic [15:0] stall_count, flush_count;

  typedef struct {
    string tag;
    fwd_e  fa;
    fwd_e  fb;
    int    sc;
    int    fc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  hazard_fwd_ctrl #(.REG_ADDR_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .branch_taken(branch_taken), .ext_hold(ext_hold),
    .ForwardA(ForwardA), .ForwardB(ForwardB),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_bubble(id_ex_bubble),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                        input logic [4:0] erd, input logic ew, input logic em,
                        input logic [4:0] mrd, input logic mw,
                        input logic bt, input logic hold, input logic r);
    id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
    ex_rd = erd; ex_reg_write = ew; ex_mem_read = em;
    mem_rd = mrd; mem_reg_write = mw;
    branch_taken = bt; ext_hold = hold; rst = r;
  endtask

  // Called just after an edge with inputs already applied.
  task automatic step(input string tag, input logic es, input logic ef,
                      input fwd_e fa, input fwd_e fb, input int sc, input int fc);
    exp_t e, got;
    #1;
    chk({tag, ".pc_stall"},     32'(pc_stall),     32'(es));
    chk({tag, ".if_id_stall"},  32'(if_id_stall),  32'(es));
    chk({tag, ".id_ex_bubble"}, 32'(id_ex_bubble), 32'(es));
    chk({tag, ".if_id_flush"},  32'(if_id_flush),  32'(ef));
    chk({tag, ".id_ex_flush"},  32'(id_ex_flush),  32'(ef));
    e.tag = tag; e.fa = fa; e.fb = fb; e.sc = sc; e.fc = fc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({got.tag, ".ForwardA"},    32'(ForwardA),    32'(got.fa));
    chk({got.tag, ".ForwardB"},    32'(ForwardB),    32'(got.fb));
    chk({got.tag, ".stall_count"}, 32'(stall_count), 32'(got.sc));
    chk({got.tag, ".flush_count"}, 32'(flush_count), 32'(got.fc));
  endtask

  initial begin
    // reset
    set_in(0,0,0,0, 0,0,0, 0,0, 0,0,1);
    step("reset0", 0, 0, from_Reg, from_Reg, 0, 0);
    step("reset1", 0, 0, from_Reg, from_Reg, 0, 0);

    // EX forward on rs1
    set_in(3,1,4,1, 3,1,0, 0,0, 0,0,0);
    step("ex_fwd_a", 0, 0, from_ex_mem, from_Reg, 0, 0);
    // EX beats MEM on rs2, then MEM when EX does not write
    set_in(1,1,5,1, 5,1,0, 5,1, 0,0,0);
    step("prio_ex_b", 0, 0, from_Reg, from_ex_mem, 0, 0);
    set_in(1,1,5,1, 5,0,0, 5,1, 0,0,0);
    step("mem_fwd_b", 0, 0, from_Reg, from_mem_wb, 0, 0);
    set_in(1,1,5,0, 5,0,0, 5,1, 0,0,0);
    step("itype_b", 0, 0, from_Reg, from_Reg, 0, 0);

    // load-use, then retry with load in MEM
    set_in(7,1,0,0, 7,1,1, 0,0, 0,0,0);
    step("luse", 1, 0, from_Reg, from_Reg, 1, 0);
    set_in(7,1,0,0, 0,0,0, 7,1, 0,0,0);
    step("luse_retry", 0, 0, from_mem_wb, from_Reg, 1, 0);

    // flush overrides load-use
    set_in(7,1,0,0, 7,1,1, 0,0, 1,0,0);
    step("luse_and_br", 0, 1, from_Reg, from_Reg, 1, 1);

    // x0 is never forwarded
    set_in(0,1,0,1, 0,1,0, 0,1, 0,0,0);
    step("x0", 0, 0, from_Reg, from_Reg, 1, 1);

    // ext_hold freezes registered state during a stall
    set_in(2,1,0,0, 2,1,0, 0,0, 0,0,0);
    step("pre_hold", 0, 0, from_ex_mem, from_Reg, 1, 1);
    set_in(7,1,0,0, 7,1,1, 0,0, 0,1,0);
    step("hold0", 1, 0, from_ex_mem, from_Reg, 1, 1);
    step("hold1", 1, 0, from_ex_mem, from_Reg, 1, 1);
    step("hold2", 1, 0, from_ex_mem, from_Reg, 1, 1);
    set_in(7,1,0,0, 7,1,1, 0,0, 0,0,0);
    step("hold_rel", 1, 0, from_Reg, from_Reg, 2, 1);

    // held branch is not counted
    set_in(0,0,0,0, 0,0,0, 0,0, 1,1,0);
    step("br_hold", 0, 1, from_Reg, from_Reg, 2, 1);
    set_in(0,0,0,0, 0,0,0, 0,0, 1,0,0);
    step("br", 0, 1, from_Reg, from_Reg, 2, 2);

    // back-to-back load-use cycles each counted
    set_in(0,0,9,1, 9,1,1, 0,0, 0,0,0);
    step("b2b0", 1, 0, from_Reg, from_Reg, 3, 2);
    step("b2b1", 1, 0, from_Reg, from_Reg, 4, 2);

    // run the stall counter up to 0xFFFE, then saturate
    for (int i = 0; i < 65530; i++) @(posedge clk);
    #1;
    chk("sat_pre.stall_count", 32'(stall_count), 32'hFFFE);
    step("sat0", 1, 0, from_Reg, from_Reg, 16'hFFFF, 2);
    step("sat1", 1, 0, from_Reg, from_Reg, 16'hFFFF, 2);
    step("sat2", 1, 0, from_Reg, from_Reg, 16'hFFFF, 2);

    // reset mid-stall: controls still combinational, registers cleared, no count
    set_in(0,0,9,1, 9,1,1, 0,0, 0,0,1);
    step("rst_stall", 1, 0, from_Reg, from_Reg, 0, 0);
    set_in(0,0,0,0, 0,0,0, 0,0, 0,0,0);
    step("post_rst", 0, 0, from_Reg, from_Reg, 0, 0);

    // reset mid-flush
    set_in(0,0,0,0, 0,0,0, 0,0, 1,0,0);
    step("flush", 0, 1, from_Reg, from_Reg, 0, 1);
    set_in(0,0,0,0, 0,0,0, 0,0, 1,0,1);
    step("rst_flush", 0, 1, from_Reg, from_Reg, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
